// File: rtl/tx_packet_framer_if.sv
//============================================================================
// Module      : tx_packet_framer_if
// Description : Signal bundle for tx_packet_framer. Carries the producer
//               word handshake (tag, data_in, data_avail, data_accept,
//               flush) and the tx FIFO write port (wdata, winc, wfull).
//               master : producer + FIFO side (testbench / top level)
//               slave  : framer side
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

interface tx_packet_framer_if;
    logic [7:0]  tag;
    logic [15:0] data_in;
    logic        data_avail;
    logic        data_accept;
    logic        flush;
    logic [7:0]  wdata;
    logic        winc;
    logic        wfull;

    modport master (
        output tag, data_in, data_avail, flush, wfull,
        input  data_accept, wdata, winc
    );

    modport slave (
        input  tag, data_in, data_avail, flush, wfull,
        output data_accept, wdata, winc
    );
endinterface

`default_nettype wire

// File: rtl/tx_packet_framer.sv
//============================================================================
// Module      : tx_packet_framer
// Description : Transmit-direction packet framer. Collects 16-bit words
//               from a producer and writes framed byte packets into the
//               write side of the tx FIFO:
//                 SYNC_BYTE, tag, seq, {msb, lsb} x count, count, checksum
//               checksum is the XOR of every byte after SYNC_BYTE up to and
//               including count.
// Ports       : clk   - system clock
//               rst   - synchronous active-high reset
//               bus   - producer handshake + tx FIFO write port (slave)
//               busy  - high whenever the framer is not idle
//               seq   - sequence number of the current/next packet
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tx_packet_framer #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         BURST_LEN = 4,
    parameter int         CNT_W     = 8
) (
    input  wire logic            clk,
    input  wire logic            rst,
    tx_packet_framer_if.slave    bus,
    output logic                 busy,
    output logic [7:0]           seq
);

    localparam logic [CNT_W-1:0] c_burst = CNT_W'(BURST_LEN);
    localparam logic [CNT_W-1:0] c_one   = CNT_W'(1);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_SYNC  = 4'd1,
        S_TAG   = 4'd2,
        S_SEQ   = 4'd3,
        S_MSB   = 4'd4,
        S_LSB   = 4'd5,
        S_WAIT  = 4'd6,
        S_COUNT = 4'd7,
        S_CSUM  = 4'd8
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [15:0]      r_word;
    logic [7:0]       r_tag;
    logic [7:0]       r_seq;
    logic [7:0]       r_csum;
    logic [CNT_W-1:0] r_cnt;
    logic             r_accept;

    logic             w_latch;      // take data_in this edge
    logic             w_byte_state; // current state emits a byte
    logic             w_xsum;       // current byte is folded into checksum
    logic             w_winc;
    logic [7:0]       w_wdata;

    //------------------------------------------------------------------
    // State register
    //------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    //------------------------------------------------------------------
    // Next state and byte outputs. Byte states only advance on a cycle
    // where the FIFO accepts the byte, so wdata stays stable under
    // backpressure.
    //------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_latch      = 1'b0;
        w_byte_state = 1'b0;
        w_xsum       = 1'b0;
        w_wdata      = 8'h00;

        case (r_state)
            S_IDLE: begin
                if (bus.data_avail) begin
                    w_latch     = 1'b1;
                    w_state_nxt = S_SYNC;
                end
            end
            S_SYNC: begin
                w_byte_state = 1'b1;
                w_wdata      = SYNC_BYTE;
                if (!bus.wfull) w_state_nxt = S_TAG;
            end
            S_TAG: begin
                w_byte_state = 1'b1;
                w_xsum       = 1'b1;
                w_wdata      = r_tag;
                if (!bus.wfull) w_state_nxt = S_SEQ;
            end
            S_SEQ: begin
                w_byte_state = 1'b1;
                w_xsum       = 1'b1;
                w_wdata      = r_seq;
                if (!bus.wfull) w_state_nxt = S_MSB;
            end
            S_MSB: begin
                w_byte_state = 1'b1;
                w_xsum       = 1'b1;
                w_wdata      = r_word[15:8];
                if (!bus.wfull) w_state_nxt = S_LSB;
            end
            S_LSB: begin
                w_byte_state = 1'b1;
                w_xsum       = 1'b1;
                w_wdata      = r_word[7:0];
                if (!bus.wfull) begin
                    w_state_nxt = (r_cnt == c_burst) ? S_COUNT : S_WAIT;
                end
            end
            S_WAIT: begin
                // A new word wins over a simultaneous flush.
                if (bus.data_avail) begin
                    w_latch     = 1'b1;
                    w_state_nxt = S_MSB;
                end else if (bus.flush) begin
                    w_state_nxt = S_COUNT;
                end
            end
            S_COUNT: begin
                w_byte_state = 1'b1;
                w_xsum       = 1'b1;
                w_wdata      = 8'(r_cnt);
                if (!bus.wfull) w_state_nxt = S_CSUM;
            end
            S_CSUM: begin
                w_byte_state = 1'b1;
                w_wdata      = r_csum;
                if (!bus.wfull) w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_winc = w_byte_state && !bus.wfull;
    end

    //------------------------------------------------------------------
    // Datapath registers
    //------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_word   <= 16'h0000;
            r_tag    <= 8'h00;
            r_seq    <= 8'h00;
            r_csum   <= 8'h00;
            r_cnt    <= '0;
            r_accept <= 1'b0;
        end else begin
            r_accept <= w_latch;

            if (w_latch) begin
                r_word <= bus.data_in;
                if (r_state == S_IDLE) begin
                    // First word opens a new packet.
                    r_tag  <= bus.tag;
                    r_csum <= 8'h00;
                    r_cnt  <= c_one;
                end else begin
                    r_cnt  <= r_cnt + c_one;
                end
            end else if (w_winc && w_xsum) begin
                r_csum <= r_csum ^ w_wdata;
            end

            if (w_winc && (r_state == S_CSUM)) begin
                r_seq <= r_seq + 8'h01;
            end
        end
    end

    assign bus.data_accept = r_accept;
    assign bus.wdata       = w_wdata;
    assign bus.winc        = w_winc;
    assign busy            = (r_state != S_IDLE);
    assign seq             = r_seq;

endmodule

`default_nettype wire

// File: tb/tb_tx_packet_framer.sv
//============================================================================
// Module      : tb_tx_packet_framer
// Description : Directed self-checking bench for tx_packet_framer.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_tx_packet_framer;

    logic       clk;
    logic       rst;
    logic       busy;
    logic [7:0] seq;

    tx_packet_framer_if bus();

    tx_packet_framer #(
        .SYNC_BYTE (8'hA5),
        .BURST_LEN (4),
        .CNT_W     (8)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy),
        .seq  (seq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_err = 0;
    int         acc_cnt = 0;
    int         winc_full_cnt = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    // Byte / handshake monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.winc) begin
                got_q.push_back(bus.wdata);
                if (bus.wfull) winc_full_cnt++;
            end
            if (bus.data_accept) acc_cnt++;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        got_q.delete();
        acc_cnt = 0;
        step();
    endtask

    task automatic send_word(input logic [15:0] w);
        bus.data_in    = w;
        bus.data_avail = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.data_accept) break;
        end
        chk("accept_seen", {31'd0, bus.data_accept}, 32'd1);
        step();
        bus.data_avail = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        chk("busy_fall", {31'd0, busy}, 32'd0);
    endtask

    task automatic compare_pkt(input string name);
        logic [7:0] obs;
        chk({name, "_len"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            obs = (i < got_q.size()) ? got_q[i] : 8'hxx;
            chk($sformatf("%s_b%0d", name, i), {24'd0, obs}, {24'd0, exp_q[i]});
        end
        got_q.delete();
    endtask

    initial begin
        logic [7:0]  t;
        logic [15:0] w;
        logic [7:0]  s;

        rst            = 1'b1;
        bus.tag        = 8'h00;
        bus.data_in    = 16'h0000;
        bus.data_avail = 1'b0;
        bus.flush      = 1'b0;
        bus.wfull      = 1'b0;
        step();
        step();
        step();
        @(negedge clk);
        chk("rst_busy",   {31'd0, busy},            32'd0);
        chk("rst_seq",    {24'd0, seq},             32'h00);
        chk("rst_winc",   {31'd0, bus.winc},        32'd0);
        chk("rst_wdata",  {24'd0, bus.wdata},       32'h00);
        chk("rst_accept", {31'd0, bus.data_accept}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        got_q.delete();
        acc_cnt = 0;
        step();

        // Single word closed by flush.
        bus.tag = 8'h01;
        send_word(16'h1234);
        bus.flush = 1'b1;
        wait_idle();
        step();
        bus.flush = 1'b0;
        exp_q = '{8'hA5, 8'h01, 8'h00, 8'h12, 8'h34, 8'h01, 8'h26};
        compare_pkt("single");
        chk("single_acc", acc_cnt, 32'd1);
        chk("single_seq", {24'd0, seq}, 32'h01);

        // Full burst, seq 0.
        do_reset();
        bus.tag = 8'h03;
        send_word(16'h0001);
        send_word(16'h0002);
        send_word(16'h0003);
        send_word(16'h0004);
        wait_idle();
        exp_q = '{8'hA5, 8'h03, 8'h00, 8'h00, 8'h01, 8'h00, 8'h02,
                  8'h00, 8'h03, 8'h00, 8'h04, 8'h04, 8'h03};
        compare_pkt("burst");
        chk("burst_acc", acc_cnt, 32'd4);
        chk("burst_seq", {24'd0, seq}, 32'h01);

        // Same burst (seq 1) with wfull held for 5 cycles on word-2 LSB.
        step();
        send_word(16'h0001);
        bus.data_in    = 16'h0002;
        bus.data_avail = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.data_accept) break;
        end
        chk("bp_accept", {31'd0, bus.data_accept}, 32'd1);
        step();
        bus.data_avail = 1'b0;
        bus.wfull      = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_winc",  {31'd0, bus.winc},  32'd0);
            chk("bp_wdata", {24'd0, bus.wdata}, 32'h02);
        end
        step();
        bus.wfull = 1'b0;
        send_word(16'h0003);
        send_word(16'h0004);
        wait_idle();
        exp_q = '{8'hA5, 8'h03, 8'h01, 8'h00, 8'h01, 8'h00, 8'h02,
                  8'h00, 8'h03, 8'h00, 8'h04, 8'h04, 8'h02};
        compare_pkt("bp");
        chk("bp_seq", {24'd0, seq}, 32'h02);

        // Sequence wrap: 257 single-word packets.
        do_reset();
        for (int i = 0; i < 257; i++) begin
            t = 8'(i) ^ 8'h5A;
            w = {8'(i), ~8'(i)};
            s = 8'(i);
            bus.tag = t;
            send_word(w);
            bus.flush = 1'b1;
            wait_idle();
            step();
            bus.flush = 1'b0;
            exp_q = '{8'hA5, t, s, w[15:8], w[7:0], 8'h01,
                      t ^ s ^ w[15:8] ^ w[7:0] ^ 8'h01};
            compare_pkt("wrap");
        end
        chk("wrap_seq", {24'd0, seq}, 32'h01);

        // data_avail and flush together in WAIT_WORD: word appended.
        bus.tag = 8'h22;
        send_word(16'hAABB);
        bus.data_in    = 16'hCCDD;
        bus.data_avail = 1'b1;
        bus.flush      = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.data_accept) break;
        end
        chk("sim_accept", {31'd0, bus.data_accept}, 32'd1);
        step();
        bus.data_avail = 1'b0;
        wait_idle();
        step();
        bus.flush = 1'b0;
        exp_q = '{8'hA5, 8'h22, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h02, 8'h21};
        compare_pkt("simul");

        // Reset during word-1 MSB.
        bus.tag = 8'h44;
        send_word(16'h5566);
        step();
        step();
        @(negedge clk);
        chk("mid_msb_winc",  {31'd0, bus.winc},  32'd1);
        chk("mid_msb_wdata", {24'd0, bus.wdata}, 32'h55);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_winc",   {31'd0, bus.winc},        32'd0);
        chk("mid_busy",   {31'd0, busy},            32'd0);
        chk("mid_accept", {31'd0, bus.data_accept}, 32'd0);
        chk("mid_seq",    {24'd0, seq},             32'h00);
        step();
        got_q.delete();
        bus.tag = 8'h77;
        send_word(16'h0102);
        bus.flush = 1'b1;
        wait_idle();
        step();
        bus.flush = 1'b0;
        exp_q = '{8'hA5, 8'h77, 8'h00, 8'h01, 8'h02, 8'h01, 8'h75};
        compare_pkt("post_rst");

        chk("winc_while_full", winc_full_cnt, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
